// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative HI/LO multiply/divide unit.
// op_legal() reflects the MULDIV_SIGNED_EN build option.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_DIVU  = 2'b01,
    OP_MULT  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [1:0] op);
`ifdef MULDIV_SIGNED_EN
    return (op == OP_MULTU) || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_DIV);
`else
    return (op == OP_MULTU) || (op == OP_DIVU);
`endif
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the decode/control path and the muldiv unit.
// master = core side, slave = muldiv_seq.
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::WIDTH_DEF
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_rd;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hilo_rd,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hilo_rd,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// Latency: combinational. Backpressure: none, the sequencer decides when to register it.
// Multiply: {hi,lo} = {acc,mplier}, opnd = multiplicand. Divide: {hi,lo} = {rem,quo}, opnd = divisor.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;

  always_comb begin
    hi_out = hi_in;
    lo_out = lo_in;
    sum    = {1'b0, hi_in} + {1'b0, (lo_in[0] ? opnd : '0)};
    // rem < divisor is invariant, so the shifted remainder fits WIDTH+1 bits
    rem_sh = {hi_in, lo_in[WIDTH-1]};
    if (is_div) begin
      if (rem_sh >= {1'b0, opnd}) begin
        hi_out = WIDTH'(rem_sh - {1'b0, opnd});
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = rem_sh[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer owning HI/LO; MULT/DIV added when MULDIV_SIGNED_EN is defined.
// Latency: WIDTH+2 cycles start-to-done (2 for divide by zero); HI/LO update atomically with done.
// Backpressure: stall = busy & (hilo_rd | start); a start is only taken while idle.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] w_hi, w_lo, w_opnd;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic             busy, accept, div_op, div_zero, step_div;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign busy     = (state != IDLE);
  assign accept   = (state == IDLE) && bus.start && op_legal(bus.op);
  assign div_op   = bus.op[0];
  assign div_zero = div_op && (bus.b == '0);
  assign step_div = (state == DIV);

`ifdef MULDIV_SIGNED_EN
  logic sgn_op;
  logic neg_prod_q, neg_quo_q, neg_rem_q;

  assign sgn_op = bus.op[1];
  assign mag_a  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Divide by zero returns raw operands, so it never takes a sign fix
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept) begin
      neg_prod_q <= sgn_op && !div_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_quo_q  <= sgn_op && div_op && !div_zero && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_rem_q  <= sgn_op && div_op && !div_zero && bus.a[WIDTH-1];
    end
  end

  always_comb begin
    res_hi = w_hi;
    res_lo = w_lo;
    if (neg_prod_q) {res_hi, res_lo} = -{w_hi, w_lo};
    if (neg_quo_q)  res_lo = -w_lo;
    if (neg_rem_q)  res_hi = -w_hi;
  end
`else
  assign mag_a  = bus.a;
  assign mag_b  = bus.b;
  assign res_hi = w_hi;
  assign res_lo = w_lo;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (step_div),
    .hi_in  (w_hi),
    .lo_in  (w_lo),
    .opnd   (w_opnd),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = div_zero ? DONE : (div_op ? DIV : MUL);
      MUL, DIV: if (cnt == LAST) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      w_opnd <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (div_zero) begin
              w_hi   <= bus.a;
              w_lo   <= '1;
              w_opnd <= '0;
            end else if (div_op) begin
              w_hi   <= '0;
              w_lo   <= mag_a;
              w_opnd <= mag_b;
            end else begin
              w_hi   <= '0;
              w_lo   <= mag_b;
              w_opnd <= mag_a;
            end
          end
        end
        MUL, DIV: begin
          w_hi <= step_hi;
          w_lo <= step_lo;
          cnt  <= cnt + CW'(1);
        end
        DONE: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.stall = busy & (bus.hilo_rd | bus.start);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic/latency model compared every cycle plus literal spot checks.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: result from plain arithmetic, busy as a cycle countdown
  int         m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit         m_done = 1'b0, m_acc = 1'b0;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit legal(input logic [1:0] op);
`ifdef MULDIV_SIGNED_EN
    return 1'b1;
`else
    return op < 2'd2;
`endif
  endfunction

  task automatic ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] h, output logic [W-1:0] l);
    logic [2*W-1:0] p;
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    h  = '0;
    l  = '0;
    if (op[0] && b == '0) begin
      h = a;
      l = '1;
    end else if (op == 2'b00) begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      h = p[2*W-1:W];
      l = p[W-1:0];
    end else if (op == 2'b01) begin
      l = a / b;
      h = a % b;
    end else if (op == 2'b10) begin
      p = sa * sb;
      h = p[2*W-1:W];
      l = p[W-1:0];
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = q;
      l = p[W-1:0];
      p = r;
      h = p[W-1:0];
    end
  endtask

  always @(posedge clk) begin
    m_acc = 1'b0;
    if (rst) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi   = p_hi;
          m_lo   = p_lo;
          m_done = 1'b1;
        end
      end else if (bus.start && legal(bus.op)) begin
        ref_result(bus.op, bus.a, bus.b, p_hi, p_lo);
        m_left = (bus.op[0] && bus.b == '0) ? 1 : W + 1;
        m_acc  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy",  bus.busy,  (m_left > 0));
      cmp("stall", bus.stall, (m_left > 0) && (bus.hilo_rd || bus.start));
      cmp("done",  bus.done,  m_done);
      cmp("hi",    bus.hi,    m_hi);
      cmp("lo",    bus.lo,    m_lo);
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int max_edges, output bit ok);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    ok        = 1'b0;
    for (int i = 0; i < max_edges && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = m_acc;
    end
    bus.start = 1'b0;
  endtask

  // Leaves the caller at the negedge of the first non-busy cycle
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int bc);
    bit ok;
    issue(op, a, b, 200, ok);
    cmp("accept", W'(ok), 1);
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      bc++;
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    cmp(name, W'(seen), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int bc, nst, ndone;
    bit ok;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.hilo_rd = 1'b0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_busy", bus.busy, 0);
    cmp("rst_done", bus.done, 0);
    cmp("rst_hi",   bus.hi,   0);
    cmp("rst_lo",   bus.lo,   0);
    rst = 1'b0;

    // 1: largest unsigned product
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
    cmp("t1_busy_cycles", bc, 33);
    cmp("t1_done", bus.done, 1);
    cmp("t1_hi", bus.hi, 32'hFFFF_FFFE);
    cmp("t1_lo", bus.lo, 32'h0000_0001);
    @(negedge clk);
    cmp("t1_done_once", bus.done, 0);

    // 2: divide, then a start presented in the done cycle
    run_op(OP_DIVU, 32'd100, 32'd7, bc);
    cmp("t2_busy_cycles", bc, 33);
    cmp("t2_lo", bus.lo, 32'd14);
    cmp("t2_hi", bus.hi, 32'd2);
    bus.start = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd3;
    bus.b     = 32'd9;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    cmp("t2_b2b_busy", bus.busy, 1);
    wait_done("t2_b2b_done");
    cmp("t2_b2b_lo", bus.lo, 32'd27);

    // 3: divide by zero bypasses iteration
    run_op(OP_DIVU, 32'h1234, 32'd0, bc);
    cmp("t3_busy_cycles", bc, 1);
    cmp("t3_done", bus.done, 1);
    cmp("t3_hi", bus.hi, 32'h0000_1234);
    cmp("t3_lo", bus.lo, 32'hFFFF_FFFF);

    // 4: MFHI/MFLO waiting on an op in flight
    issue(OP_MULTU, 32'd6, 32'd7, 10, ok);
    bus.hilo_rd = 1'b1;
    nst = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (bus.stall) nst++;
    end
    cmp("t4_stall_cycles", nst, 33);
    cmp("t4_stall_done", bus.stall, 0);
    cmp("t4_done", bus.done, 1);
    cmp("t4_lo", bus.lo, 32'd42);
    bus.hilo_rd = 1'b0;

    // 5: start while busy is held off, then taken
    issue(OP_MULTU, 32'd3, 32'd5, 10, ok);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd50;
    bus.b     = 32'd5;
    @(negedge clk);
    cmp("t5_stall", bus.stall, 1);
    cmp("t5_lo_hold", bus.lo, 32'd42);
    issue(OP_DIVU, 32'd50, 32'd5, 100, ok);
    @(negedge clk);
    cmp("t5_first_lo", bus.lo, 32'd15);
    cmp("t5_second_busy", bus.busy, 1);
    wait_done("t5_second_done");
    cmp("t5_second_lo", bus.lo, 32'd10);

    // 5b: reset mid-operation
    issue(OP_MULTU, 32'hFFFF, 32'hFFFF, 10, ok);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    cmp("t5_rst_busy", bus.busy, 0);
    cmp("t5_rst_hi", bus.hi, 0);
    cmp("t5_rst_lo", bus.lo, 0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    cmp("t5_rst_no_done", ndone, 0);

`ifdef MULDIV_SIGNED_EN
    // 6: signed ops
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, bc);
    cmp("t6_mult_cycles", bc, 33);
    cmp("t6_mult_hi", bus.hi, 32'hFFFF_FFFF);
    cmp("t6_mult_lo", bus.lo, 32'hFFFF_FFF1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc);
    cmp("t6_div_lo", bus.lo, 32'hFFFF_FFFD);
    cmp("t6_div_hi", bus.hi, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
    cmp("t6_ovf_lo", bus.lo, 32'h8000_0000);
    cmp("t6_ovf_hi", bus.hi, 32'h0000_0000);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, bc);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, bc);
    cmp("t6_minmin_hi", bus.hi, 32'h4000_0000);
`else
    // 6: reserved signed ops are ignored
    #1;
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(negedge clk);
    cmp("t6_rsv_stall", bus.stall, 0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    cmp("t6_rsv_busy", bus.busy, 0);
    cmp("t6_rsv_lo", bus.lo, 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
